fifo_pkt_writer: RTL and testbench

- Write-side controller for the router's packet FIFO memory.
- Accepts a byte stream over a valid/ready handshake and parses the packet format: source_id, dest_id, size, size payload bytes, crc.
- Allocates a free packet slot and drives the memory write port (waddr = slot, waddr_in = byte index, wdata).
- Tracks slot occupancy, checks the CRC, and releases slots when downstream readers report them consumed.

---
 rtl/fifo_pkt_writer.sv | 155 +++++++++++++++
 tb/tb_fifo_pkt_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_writer.sv
// Write-side controller for the router packet FIFO: parses src/dst/size/payload/crc,
// writes each byte into a free slot one cycle after acceptance, and tracks slot occupancy.
module fifo_pkt_writer #(
  parameter int PTR_SZ      = 2,
  parameter int PTR_IN_SZ   = 4,
  parameter int UWIDTH      = 8,
  parameter int MAX_PAYLOAD = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [UWIDTH-1:0]      in_data,
  output logic                   in_ready,
  output logic                   write_en,
  output logic [PTR_SZ-1:0]      waddr,
  output logic [PTR_IN_SZ-1:0]   waddr_in,
  output logic [UWIDTH-1:0]      wdata,
  input  logic                   rel_en,
  input  logic [PTR_SZ-1:0]      rel_slot,
  output logic [2**PTR_SZ-1:0]   occupied,
  output logic                   full,
  output logic                   pkt_done,
  output logic [PTR_SZ-1:0]      pkt_slot,
  output logic [UWIDTH-1:0]      pkt_dest,
  output logic                   pkt_err
);

  localparam int NSLOT = 2**PTR_SZ;
  localparam int CW    = UWIDTH + 1;  // DRAIN loads size+1, which can exceed a byte
  localparam logic [UWIDTH-1:0] MAX_P = UWIDTH'(MAX_PAYLOAD);
  localparam logic [CW-1:0]     ONE   = CW'(1);

  typedef enum logic [2:0] {
    WAIT_SLOT, HDR_SRC, HDR_DST, HDR_SIZE, PAYLOAD, CRC, DRAIN
  } state_t;

  state_t                state, state_nxt;
  logic [PTR_SZ-1:0]     cur_slot, free_slot;
  logic                  free_any;
  logic [UWIDTH-1:0]     dest, crc_acc;
  logic [CW-1:0]         cnt;
  logic [PTR_IN_SZ-1:0]  idx;
  logic [NSLOT-1:0]      occ_nxt;
  logic                  accept, writing, size_big, crc_ok, commit, discard;

  assign accept   = in_valid && in_ready;
  assign writing  = (state == HDR_SRC) || (state == HDR_DST) || (state == HDR_SIZE) ||
                    (state == PAYLOAD) || (state == CRC);
  assign size_big = in_data > MAX_P;
  assign crc_ok   = in_data == crc_acc;
  assign commit   = accept && (state == CRC) && crc_ok;
  assign discard  = accept && (((state == CRC) && !crc_ok) ||
                               ((state == DRAIN) && (cnt == ONE)));

  // Lowest free slot wins: scan downward so the smallest index is assigned last.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    free_any  = ~&occupied;
    free_slot = '0;
    for (int i = NSLOT - 1; i >= 0; i--)
      if (!occupied[i]) free_slot = PTR_SZ'(i);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_SLOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SLOT: if (free_any) state_nxt = HDR_SRC;
      HDR_SRC:   if (accept) state_nxt = HDR_DST;
      HDR_DST:   if (accept) state_nxt = HDR_SIZE;
      HDR_SIZE:
        if (accept) begin
          if (in_data == '0) state_nxt = CRC;
          else if (size_big) state_nxt = DRAIN;
          else               state_nxt = PAYLOAD;
        end
      PAYLOAD:   if (accept && cnt == ONE) state_nxt = CRC;
      CRC:       if (accept) state_nxt = WAIT_SLOT;
      DRAIN:     if (accept && cnt == ONE) state_nxt = WAIT_SLOT;
      default:   state_nxt = WAIT_SLOT;
    endcase
  end

  always_comb begin
    in_ready = (state != WAIT_SLOT);
  end

  // Release and commit never target the same slot, so their order here is immaterial.
  always_comb begin
    occ_nxt = occupied;
    if (rel_en) occ_nxt[rel_slot] = 1'b0;
    if (commit) occ_nxt[cur_slot] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en <= 1'b0;
      waddr    <= '0;
      waddr_in <= '0;
      wdata    <= '0;
      cur_slot <= '0;
      dest     <= '0;
      crc_acc  <= '0;
      cnt      <= '0;
      idx      <= '0;
      occupied <= '0;
      full     <= 1'b0;
      pkt_done <= 1'b0;
      pkt_slot <= '0;
      pkt_dest <= '0;
      pkt_err  <= 1'b0;
    end else begin
      write_en <= accept && writing;
      if (accept && writing) begin
        waddr    <= cur_slot;
        waddr_in <= idx;
        wdata    <= in_data;
      end

      if (state == WAIT_SLOT && free_any) begin
        cur_slot <= free_slot;
        crc_acc  <= '0;
        idx      <= '0;
      end else if (accept && writing) begin
        idx     <= idx + 1'b1;
        crc_acc <= crc_acc ^ in_data;
      end

      if (accept && state == HDR_DST) dest <= in_data;

      if (accept) begin
        case (state)
          HDR_SIZE:       cnt <= size_big ? {1'b0, in_data} + ONE : {1'b0, in_data};
          PAYLOAD, DRAIN: cnt <= cnt - ONE;
          default:        cnt <= cnt;
        endcase
      end

      occupied <= occ_nxt;
      full     <= &occ_nxt;
      pkt_done <= commit;
      pkt_err  <= discard;
      if (commit) begin
        pkt_slot <= cur_slot;
        pkt_dest <= dest;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed self-checking bench for fifo_pkt_writer: a monitor logs writes and
// commit/discard pulses, and each scenario compares them to hand-computed tables.
module tb_fifo_pkt_writer;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       write_en;
  logic [1:0] waddr;
  logic [3:0] waddr_in;
  logic [7:0] wdata;
  logic       rel_en;
  logic [1:0] rel_slot;
  logic [3:0] occupied;
  logic       full;
  logic       pkt_done;
  logic [1:0] pkt_slot;
  logic [7:0] pkt_dest;
  logic       pkt_err;

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;
  int err_cnt  = 0;
  logic [13:0] wr_q[$];
  logic [9:0]  done_q[$];

  fifo_pkt_writer #(.PTR_SZ(2), .PTR_IN_SZ(4), .UWIDTH(8), .MAX_PAYLOAD(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write_en(write_en), .waddr(waddr), .waddr_in(waddr_in), .wdata(wdata),
    .rel_en(rel_en), .rel_slot(rel_slot), .occupied(occupied), .full(full),
    .pkt_done(pkt_done), .pkt_slot(pkt_slot), .pkt_dest(pkt_dest), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  // Registered outputs are sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (write_en) wr_q.push_back({waddr, waddr_in, wdata});
    if (pkt_done) done_q.push_back({pkt_slot, pkt_dest});
    if (pkt_err)  err_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_q.delete();
    done_q.delete();
    err_cnt = 0;
  endtask

  // Entered and left at a falling edge; the byte is accepted at the rising edge in between.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t p, input int gap);
    foreach (p[i]) begin
      send_byte(p[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic release_slot(input logic [1:0] s);
    rel_en   = 1'b1;
    rel_slot = s;
    @(negedge clk);
    rel_en   = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [1:0] slot, input byte_q_t exp);
    check({tag, "_nwr"}, wr_q.size(), exp.size());
    foreach (exp[i])
      if (i < wr_q.size())
        check({tag, "_wr"}, {18'd0, wr_q[i]}, {18'd0, slot, 4'(i), exp[i]});
  endtask

  task automatic check_done(input string tag, input int k, input logic [1:0] slot,
                            input logic [7:0] dst);
    if (k < done_q.size()) check({tag, "_done"}, {22'd0, done_q[k]}, {22'd0, slot, dst});
    else                   check({tag, "_done_missing"}, done_q.size(), k + 1);
  endtask

  initial begin
    byte_q_t p;
    logic [7:0] crc_tbl [4];
    crc_tbl = '{8'd6, 8'd5, 8'd4, 8'd3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; rel_en = 1'b0; rel_slot = '0;
    idle(2);
    check("rst_in_ready", in_ready, 0);
    check("rst_write_en", write_en, 0);
    check("rst_occupied", occupied, 4'h0);
    check("rst_full", full, 0);
    check("rst_pulses", {pkt_done, pkt_err}, 2'b00);

    // 1: good packet back-to-back from reset
    rst = 1'b0;
    clear_log();
    p = {8'd10, 8'd5, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
    send_pkt(p, 0);
    idle(2);
    check_writes("t1", 2'd0, p);
    check("t1_ndone", done_q.size(), 1);
    check_done("t1", 0, 2'd0, 8'd5);
    check("t1_occ", occupied, 4'h1);
    check("t1_err", err_cnt, 0);

    // 2: fill all four slots, then offer a fifth until a release frees slot 2
    rst = 1'b1; idle(1); rst = 1'b0;
    clear_log();
    for (int d = 1; d <= 4; d++) begin
      p = {8'd1, 8'(d), 8'd1, 8'd7, crc_tbl[d-1]};
      send_pkt(p, 0);
    end
    idle(2);
    check("t2_ndone", done_q.size(), 4);
    for (int i = 0; i < 4; i++) check_done("t2", i, 2'(i), 8'(i + 1));
    check("t2_occ", occupied, 4'hF);
    check("t2_full", full, 1);
    clear_log();
    in_valid = 1'b1; in_data = 8'd9;
    idle(4);
    check("t2_ready_full", in_ready, 0);
    check("t2_no_write_full", wr_q.size(), 0);
    release_slot(2'd2);
    check("t2_occ_rel", occupied, 4'hB);
    check("t2_full_rel", full, 0);
    p = {8'd9, 8'd8, 8'd0, 8'd1};
    send_pkt(p, 0);
    idle(2);
    check_writes("t2_fifth", 2'd2, p);
    check_done("t2_fifth", 0, 2'd2, 8'd8);
    check("t2_full_again", full, 1);

    // 3: bad crc keeps the slot free; next packet reuses it. Double release is ignored.
    release_slot(2'd1);
    release_slot(2'd1);
    check("t3_occ_rel", occupied, 4'hD);
    clear_log();
    p = {8'd10, 8'd5, 8'd3, 8'd0, 8'd1, 8'd2, 8'd14};
    send_pkt(p, 0);
    idle(2);
    check_writes("t3", 2'd1, p);
    check("t3_err", err_cnt, 1);
    check("t3_ndone", done_q.size(), 0);
    check("t3_occ", occupied, 4'hD);
    clear_log();
    p = {8'd10, 8'd5, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
    send_pkt(p, 0);
    idle(2);
    check_done("t3_reuse", 0, 2'd1, 8'd5);
    check("t3_occ_reuse", occupied, 4'hF);

    // 4: oversize packet drains 14 bytes with only the header written
    release_slot(2'd3);
    clear_log();
    p = {8'd20, 8'd21, 8'd13};
    send_pkt(p, 0);
    stalls = 0;
    for (int i = 0; i < 14; i++) send_byte(8'(i + 100));
    idle(2);
    check("t4_stalls", stalls, 0);
    check_writes("t4", 2'd3, p);
    check("t4_err", err_cnt, 1);
    check("t4_ndone", done_q.size(), 0);
    check("t4_occ", occupied, 4'h7);

    // 5: size-0 packet with in_valid low every other cycle
    clear_log();
    p = {8'd1, 8'd2, 8'd0, 8'd3};
    send_pkt(p, 1);
    idle(2);
    check_writes("t5", 2'd3, p);
    check_done("t5", 0, 2'd3, 8'd2);
    check("t5_full", full, 1);

    // 6: reset mid-packet in slot 1 with slot 0 occupied
    rst = 1'b1; idle(1); rst = 1'b0;
    clear_log();
    p = {8'd1, 8'd2, 8'd0, 8'd3};
    send_pkt(p, 0);
    p = {8'd5, 8'd6, 8'd4, 8'd10, 8'd11};
    send_pkt(p, 0);
    check("t6_pre_occ", occupied, 4'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_write", write_en, 0);
    check("t6_rst_bus", {waddr, waddr_in, wdata}, 14'd0);
    check("t6_rst_occ", {occupied, full}, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    p = {8'd7, 8'd8, 8'd0, 8'd15};
    send_pkt(p, 0);
    idle(2);
    check("t6_ndone", done_q.size(), 2);
    check_done("t6_first", 0, 2'd0, 8'd2);
    check_done("t6_after", 1, 2'd0, 8'd8);
    check("t6_err", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
